// File: rtl/adc_spi_pkg.sv
// Shared constants for the ADC SPI slave model: frame geometry, channel field
// position and FSM state encodings.
package adc_spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
endpackage

// File: rtl/adc_spi_if.sv
// SPI bus between an external master and the ADC model.
interface adc_spi_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc_spi_shift.sv
// SPI front end: synchronizers, edge detection, RX/TX shift registers and the
// frame bit counter. Sequencing decisions are made by the parent FSM.
module adc_spi_shift
  import adc_spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  shift_en_i,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] load_val_i,
  output logic                  ss_fall_o,
  output logic                  ss_rise_o,
  output logic                  sclk_rise_o,
  output logic [2:0]            ch_addr_o,
  output logic                  tx_msb_o,
  output logic [CNT_W-1:0]      bit_cnt_o
);
  logic [2:0]            ss_q, sclk_q;
  logic [1:0]            mosi_q;
  logic [FRAME_BITS-1:0] rx_q, tx_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sclk_fall;
  logic                  unused_rx;

  // Bits [1:0] are the synchronizer, bit [2] holds the previous value for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n_i};
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
      cnt_q  <= cnt_d;
    end
  end

  assign ss_fall_o   =  ss_q[2]   & ~ss_q[1];
  assign ss_rise_o   = ~ss_q[2]   &  ss_q[1];
  assign sclk_rise_o = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall   =  sclk_q[2] & ~sclk_q[1];

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (shift_en_i && sclk_rise_o)
      cnt_d = cnt_q + 5'd1;
  end

  // SCLK idles high, so the first fall precedes any rise; TX only advances
  // once a bit has been sampled, keeping the MSB on the line for rise one.
  always_ff @(posedge clk) begin
    if (load_i)
      tx_q <= load_val_i;
    else if (shift_en_i && sclk_fall && (cnt_q != '0))
      tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
    if (shift_en_i && sclk_rise_o)
      rx_q <= {rx_q[FRAME_BITS-2:0], mosi_q[1]};
  end

  assign ch_addr_o = rx_q[CH_MSB:CH_LSB];
  assign tx_msb_o  = tx_q[FRAME_BITS-1];
  assign bit_cnt_o = cnt_q;
  assign unused_rx = ^{rx_q[FRAME_BITS-1:CH_MSB+1], rx_q[CH_LSB-1:0]};
endmodule

// File: rtl/adc_spi_model.sv
// Behavioural ADC behind an SPI slave: each 16-bit frame returns the value of
// the channel addressed by the previous frame.
module adc_spi_model
  import adc_spi_pkg::*;
#(
  parameter int             NUM_CH   = 8,
  parameter int             RES      = 12,
  parameter logic [7:0]     CH_MASK  = 8'hFF,
  parameter logic [RES-1:0] ERR_CODE = {RES{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  adc_spi_if.slave              spi,
  input  logic [NUM_CH*RES-1:0] ch_data,
  output logic                  frame_done,
  output logic [2:0]            last_ch,
  output logic                  bad_ch,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);
  logic [1:0]       state_q, state_d;
  logic             upd_q, upd_d, init_q;
  logic             frame_done_q, bad_ch_q, frame_err_q, err_d;
  logic [2:0]       last_ch_q;
  logic [15:0]      frame_cnt_q;
  logic [RES-1:0]   held_q, sel_val;
  logic             ss_fall, ss_rise, sclk_rise, tx_msb, load, shift_en;
  logic [2:0]       ch_addr;
  logic [CNT_W-1:0] bit_cnt;

  function automatic logic ch_ok(input logic [2:0] a);
    return (int'(a) < NUM_CH) && CH_MASK[a];
  endfunction

  assign shift_en = (state_q == SHIFT);

  adc_spi_shift u_shift (
    .clk         (clk),
    .rst         (rst),
    .ss_n_i      (spi.SS_n),
    .sclk_i      (spi.SCLK),
    .mosi_i      (spi.MOSI),
    .shift_en_i  (shift_en),
    .load_i      (load),
    .load_val_i  ({{(FRAME_BITS-RES){1'b0}}, held_q}),
    .ss_fall_o   (ss_fall),
    .ss_rise_o   (ss_rise),
    .sclk_rise_o (sclk_rise),
    .ch_addr_o   (ch_addr),
    .tx_msb_o    (tx_msb),
    .bit_cnt_o   (bit_cnt)
  );

  // SCLK edges in IDLE are never looked at, so a coincident SS_n fall wins.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    err_d   = 1'b0;
    upd_d   = 1'b0;
    case (state_q)
      IDLE:  if (ss_fall) begin
               state_d = SHIFT;
               load    = 1'b1;
             end
      SHIFT: if (ss_rise) begin
               state_d = IDLE;
               err_d   = (bit_cnt != '0);
             end else if (sclk_rise && (bit_cnt == LAST_BIT)) begin
               state_d = HOLD;
               upd_d   = 1'b1;
             end
      HOLD:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (int'(ch_addr) == i) sel_val = ch_data[i*RES +: RES];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      upd_q        <= 1'b0;
      init_q       <= 1'b1;
      frame_done_q <= 1'b0;
      bad_ch_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      last_ch_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      upd_q        <= upd_d;
      init_q       <= 1'b0;
      frame_done_q <= upd_q;
      bad_ch_q     <= upd_q && !ch_ok(ch_addr);
      frame_err_q  <= err_d;
      if (upd_q) begin
        last_ch_q   <= ch_addr;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // The held sample is refreshed from channel 0 right after reset release.
  always_ff @(posedge clk) begin
    if (init_q)
      held_q <= ch_ok(3'd0) ? ch_data[RES-1:0] : ERR_CODE;
    else if (upd_q)
      held_q <= ch_ok(ch_addr) ? sel_val : ERR_CODE;
  end

  assign spi.MISO  = shift_en & tx_msb;
  assign frame_done = frame_done_q;
  assign last_ch    = last_ch_q;
  assign bad_ch     = bad_ch_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_adc_spi_model.sv
// Drives three differently configured ADC models with identical SPI traffic
// and checks each against a per-configuration reference model.
module tb_adc_spi_model;
  logic clk = 1'b0;
  logic rst;
  logic ss_n, sclk, mosi;
  always #5 clk = ~clk;

  logic [95:0] ch_a;
  logic [47:0] ch_b;
  logic [79:0] ch_c;
  logic        fd [3], bc [3], fe [3], miso [3];
  logic [2:0]  lc [3];
  logic [15:0] fc [3];

  adc_spi_if spi_a ();
  adc_spi_if spi_b ();
  adc_spi_if spi_c ();
  assign spi_a.SS_n = ss_n;  assign spi_a.SCLK = sclk;  assign spi_a.MOSI = mosi;
  assign spi_b.SS_n = ss_n;  assign spi_b.SCLK = sclk;  assign spi_b.MOSI = mosi;
  assign spi_c.SS_n = ss_n;  assign spi_c.SCLK = sclk;  assign spi_c.MOSI = mosi;
  assign miso[0] = spi_a.MISO;
  assign miso[1] = spi_b.MISO;
  assign miso[2] = spi_c.MISO;

  adc_spi_model #(.NUM_CH(8), .RES(12)) u_a (
    .clk(clk), .rst(rst), .spi(spi_a), .ch_data(ch_a), .frame_done(fd[0]),
    .last_ch(lc[0]), .bad_ch(bc[0]), .frame_err(fe[0]), .frame_cnt(fc[0]));
  adc_spi_model #(.NUM_CH(4), .RES(12), .CH_MASK(8'h0D)) u_b (
    .clk(clk), .rst(rst), .spi(spi_b), .ch_data(ch_b), .frame_done(fd[1]),
    .last_ch(lc[1]), .bad_ch(bc[1]), .frame_err(fe[1]), .frame_cnt(fc[1]));
  adc_spi_model #(.NUM_CH(8), .RES(10)) u_c (
    .clk(clk), .rst(rst), .spi(spi_c), .ch_data(ch_c), .frame_done(fd[2]),
    .last_ch(lc[2]), .bad_ch(bc[2]), .frame_err(fe[2]), .frame_cnt(fc[2]));

  // Reference configuration and state
  int nch [3] = '{8, 4, 8};
  int res [3] = '{12, 12, 10};
  int msk [3] = '{8'hFF, 8'h0D, 8'hFF};
  int chv [3][8];
  int held [3], cnt [3], last [3];

  int n_chk = 0, n_fail = 0;
  int done_n [3], bad_n [3], err_n [3], lone_bad [3];
  int d0 [3], b0 [3], e0 [3];
  logic [31:0] word [3];

  initial for (int k = 0; k < 3; k++) begin
    done_n[k] = 0; bad_n[k] = 0; err_n[k] = 0; lone_bad[k] = 0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      done_n[k] = done_n[k] + int'(fd[k]);
      bad_n[k]  = bad_n[k] + int'(bc[k]);
      err_n[k]  = err_n[k] + int'(fe[k]);
      if (bc[k] && !fd[k]) lone_bad[k] = lone_bad[k] + 1;
    end
  end

  function automatic bit valid(input int k, input int a);
    return (a < nch[k]) && msk[k][a];
  endfunction

  function automatic int errc(input int k);
    return (1 << res[k]) - 1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      held[k] = valid(k, 0) ? chv[k][0] : errc(k);
      cnt[k]  = 0;
      last[k] = 0;
    end
  endtask

  // Raw SPI master (mode 3): data set while SCLK low, sampled on the rise.
  task automatic spi_xfer(input logic [15:0] cmd, input int nbits);
    for (int k = 0; k < 3; k++) word[k] = '0;
    ss_n = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = (i < 16) ? cmd[15-i] : 1'b0;
      #80;
      for (int k = 0; k < 3; k++) word[k] = {word[k][30:0], miso[k]};
      sclk = 1'b1;
      #80;
    end
    ss_n = 1'b1;
    #100;
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nbits);
    int a;
    logic [31:0] expw;
    bit bad;
    a = int'(cmd[13:11]);
    for (int k = 0; k < 3; k++) begin
      d0[k] = done_n[k]; b0[k] = bad_n[k]; e0[k] = err_n[k];
    end
    spi_xfer(cmd, nbits);
    for (int k = 0; k < 3; k++) begin
      if (nbits >= 16) expw = 32'(held[k]) << (nbits - 16);
      else             expw = 32'(held[k]) >> (16 - nbits);
      chk("miso_word", k, word[k], expw);
      bad = 1'b0;
      if (nbits >= 16) begin
        bad     = !valid(k, a);
        held[k] = bad ? errc(k) : chv[k][a];
        last[k] = a;
        cnt[k]  = (cnt[k] + 1) & 16'hFFFF;
      end
      chk("frame_done_pulses", k, 32'(done_n[k] - d0[k]), (nbits >= 16) ? 32'd1 : 32'd0);
      chk("bad_ch_pulses", k, 32'(bad_n[k] - b0[k]), 32'(bad));
      chk("frame_err_pulses", k, 32'(err_n[k] - e0[k]),
          (nbits >= 1 && nbits <= 15) ? 32'd1 : 32'd0);
      chk("frame_cnt", k, 32'(fc[k]), 32'(cnt[k]));
      chk("last_ch", k, 32'(lc[k]), 32'(last[k]));
      chk("miso_idle", k, 32'(miso[k]), 32'd0);
    end
  endtask

  initial begin
    ss_n = 1'b1; sclk = 1'b1; mosi = 1'b0; rst = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) chv[k][i] = int'($urandom) & errc(k);
    chv[0][0] = 12'hC00;
    chv[0][4] = 12'h5A5;
    chv[2][2] = 10'h3FF;
    for (int i = 0; i < 8; i++) ch_a[i*12 +: 12] = chv[0][i][11:0];
    for (int i = 0; i < 4; i++) ch_b[i*12 +: 12] = chv[1][i][11:0];
    for (int i = 0; i < 8; i++) ch_c[i*10 +: 10] = chv[2][i][9:0];
    #32;
    for (int k = 0; k < 3; k++) begin
      chk("rst_miso", k, 32'(miso[k]), 32'd0);
      chk("rst_frame_cnt", k, 32'(fc[k]), 32'd0);
      chk("rst_last_ch", k, 32'(lc[k]), 32'd0);
      chk("rst_pulses", k, 32'({fd[k], bc[k], fe[k]}), 32'd0);
    end
    rst = 1'b0;
    model_reset();
    #50;

    // Pipeline: address 4, then 0 (0C00 / 05A5 on the default config)
    run_frame({2'b00, 3'd4, 11'h155}, 16);
    run_frame({2'b10, 3'd0, 11'h0AA}, 16);
    chk("req_word_ch4", 0, word[0], 32'h05A5);
    // Masked channel 1 on the 4-channel config, then channel 2 (RES=10 all ones)
    run_frame({2'b01, 3'd1, 11'h7FF}, 16);
    run_frame({2'b00, 3'd2, 11'h000}, 16);
    chk("req_word_err", 1, word[1], 32'h0FFF);
    run_frame({2'b11, 3'd5, 11'h123}, 16);
    chk("req_word_res10", 2, word[2], 32'h03FF);

    // Aborted frames and extra clocks in HOLD
    run_frame(16'(($urandom)), 9);
    run_frame(16'(($urandom)), 16);
    run_frame(16'(($urandom)), 0);
    run_frame(16'(($urandom)), 18);
    for (int n = 0; n < 12; n++) run_frame(16'($urandom), 16);
    run_frame(16'($urandom), $urandom_range(1, 15));
    run_frame(16'($urandom), 16);

    // Counter wrap
    force u_a.frame_cnt_q = 16'hFFFF;
    #10;
    release u_a.frame_cnt_q;
    cnt[0] = 16'hFFFF;
    chk("preload_cnt", 0, 32'(fc[0]), 32'hFFFF);
    run_frame({2'b00, 3'd3, 11'h001}, 16);

    // Reset in the middle of a frame
    for (int k = 0; k < 3; k++) e0[k] = err_n[k];
    ss_n = 1'b0;
    #80;
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b0; mosi = 1'($urandom); #80;
      sclk = 1'b1; #80;
    end
    rst = 1'b1;
    #20;
    for (int k = 0; k < 3; k++) chk("midrst_miso", k, 32'(miso[k]), 32'd0);
    ss_n = 1'b1;
    #50;
    rst = 1'b0;
    model_reset();
    #100;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_no_err", k, 32'(err_n[k] - e0[k]), 32'd0);
      chk("midrst_cnt", k, 32'(fc[k]), 32'd0);
    end
    run_frame(16'($urandom), 16);
    chk("midrst_ch0", 0, word[0], 32'h0C00);

    for (int k = 0; k < 3; k++) chk("bad_without_done", k, 32'(lone_bad[k]), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
